// File: rtl/mac_dot_seq.sv
// mac_dot_seq: drives a single multiply-accumulate unit through one dot product,
// result = bias + sum(x[i]*w[i]) for i in [0, len).
// Operand pairs come from two synchronous-read RAMs. Each term is split into a
// fetch, an addend beat, a multiplicand beat and a bounded wait for the MAC
// result. The MAC result is fed back as the addend of the next term.
module mac_dot_seq #(
  parameter int N       = 32,
  parameter int AW      = 10,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   len,
  input  logic [31:0]   bias,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [31:0]   result,
  output logic          x_rd_en,
  output logic          w_rd_en,
  output logic [AW-1:0] x_addr,
  output logic [AW-1:0] w_addr,
  input  logic [N-1:0]  x_rd_data,
  input  logic [N-1:0]  w_rd_data,
  output logic          mac_ce,
  output logic          mac_addend_vld,
  output logic [31:0]   mac_addend_din,
  output logic          mac_multiplicand_vld,
  output logic [N-1:0]  mac_multiplicand_din,
  output logic [N-1:0]  mac_multiplier_din,
  input  logic [31:0]   mac_dout,
  input  logic          mac_dout_vld
);

  // Wide enough to hold TIMEOUT-1 without wrapping during the compare.
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ADD,
    S_MUL,
    S_WAIT,
    S_FIN,
    S_ERR
  } state_t;

  state_t          state_reg;
  logic [31:0]     acc_reg;
  logic [AW-1:0]   idx_reg;
  // Index of the last term (len-1); len==0 never reaches a compare against it.
  logic [AW-1:0]   last_idx_reg;
  logic [TW-1:0]   timer_reg;

  logic            busy_reg;
  logic            done_reg;
  logic            err_reg;
  logic [31:0]     result_reg;
  logic            rd_en_reg;
  logic [AW-1:0]   addr_reg;
  logic            addend_vld_reg;
  logic [31:0]     addend_din_reg;
  logic            mcand_vld_reg;
  logic [N-1:0]    mcand_reg;
  logic [N-1:0]    mult_reg;

  logic            last_term;
  logic            timer_expired;

  assign last_term     = (idx_reg == last_idx_reg);
  assign timer_expired = (timer_reg == TW'(TIMEOUT - 1));

  // Sequencer FSM: strobes are registered on entry to the state that owns them,
  // so rd_en is high during FETCH, addend_vld during ADD and multiplicand_vld
  // during MUL; done/result/err appear the cycle after FIN/ERR.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      acc_reg        <= '0;
      idx_reg        <= '0;
      last_idx_reg   <= '0;
      timer_reg      <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      result_reg     <= '0;
      rd_en_reg      <= 1'b0;
      addr_reg       <= '0;
      addend_vld_reg <= 1'b0;
      addend_din_reg <= '0;
      mcand_vld_reg  <= 1'b0;
      mcand_reg      <= '0;
      mult_reg       <= '0;
    end else begin
      // One-cycle strobes default low; the owning state raises them.
      rd_en_reg      <= 1'b0;
      addend_vld_reg <= 1'b0;
      mcand_vld_reg  <= 1'b0;
      done_reg       <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (start) begin
            last_idx_reg <= AW'(len - 1'b1);
            acc_reg      <= bias;
            idx_reg      <= '0;
            err_reg      <= 1'b0;
            busy_reg     <= 1'b1;
            if (len == '0) begin
              state_reg <= S_FIN;
            end else begin
              state_reg <= S_FETCH;
              rd_en_reg <= 1'b1;
              addr_reg  <= '0;
            end
          end else begin
            // busy stays up through the done cycle and drops here.
            busy_reg <= 1'b0;
          end
        end

        S_FETCH: begin
          // RAM data for idx arrives during ADD.
          addend_vld_reg <= 1'b1;
          addend_din_reg <= acc_reg;
          state_reg      <= S_ADD;
        end

        S_ADD: begin
          mcand_reg     <= x_rd_data;
          mult_reg      <= w_rd_data;
          mcand_vld_reg <= 1'b1;
          state_reg     <= S_MUL;
        end

        S_MUL: begin
          timer_reg <= '0;
          state_reg <= S_WAIT;
        end

        S_WAIT: begin
          timer_reg <= timer_reg + 1'b1;
          // A result arriving on the timeout cycle still counts as success.
          if (mac_dout_vld) begin
            acc_reg <= mac_dout;
            if (last_term) begin
              state_reg <= S_FIN;
            end else begin
              idx_reg   <= idx_reg + 1'b1;
              addr_reg  <= idx_reg + 1'b1;
              rd_en_reg <= 1'b1;
              state_reg <= S_FETCH;
            end
          end else if (timer_expired) begin
            state_reg <= S_ERR;
          end
        end

        S_FIN: begin
          result_reg <= acc_reg;
          done_reg   <= 1'b1;
          state_reg  <= S_IDLE;
        end

        S_ERR: begin
          // Report the partial sum accumulated before the stall.
          err_reg    <= 1'b1;
          result_reg <= acc_reg;
          done_reg   <= 1'b1;
          state_reg  <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign busy                 = busy_reg;
  assign done                 = done_reg;
  assign err                  = err_reg;
  assign result               = result_reg;
  assign x_rd_en              = rd_en_reg;
  assign w_rd_en              = rd_en_reg;
  assign x_addr               = addr_reg;
  assign w_addr               = addr_reg;
  assign mac_ce               = busy_reg;
  assign mac_addend_vld       = addend_vld_reg;
  assign mac_addend_din       = addend_din_reg;
  assign mac_multiplicand_vld = mcand_vld_reg;
  assign mac_multiplicand_din = mcand_reg;
  assign mac_multiplier_din   = mult_reg;

endmodule

// File: doc/mac_dot_seq.md
Name: mac_dot_seq

Overview:
- Sequencer that drives one mac_unit instance to compute a dot product: result = bias + sum over i in [0, len) of x[i]*w[i].
- Fetches operand pairs from two synchronous-read RAMs (feature x, weight w).
- Feeds the running accumulator back to the MAC as the addend, and the multiplicand one cycle after the addend (the MAC requires addend first).
- Sits between the FC-layer control FSM and the MAC datapath; one neuron per start.

Parameters:
- N, 32: operand width of x/w and of the MAC multiplicand/multiplier.
- AW, 10: RAM address width; max len = 2^AW.
- TIMEOUT, 64: max cycles waited in WAIT for mac_dout_vld before error.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  1-cycle request; sampled only in IDLE.
- len  in  AW+1  number of terms, latched at start.
- bias  in  32  initial accumulator, latched at start.
- busy  out  1  high in every state except IDLE.
- done  out  1  1-cycle pulse at completion (normal or error).
- err  out  1  sticky timeout flag; cleared by accepted start or rst.
- result  out  32  final accumulator; valid from done, held until next accepted start.
- x_rd_en, w_rd_en  out  1  RAM read strobes.
- x_addr, w_addr  out  AW  RAM addresses, both equal idx.
- x_rd_data, w_rd_data  in  N  read data, valid the cycle after rd_en.
- mac_ce  out  1  MAC clock enable, equal to busy.
- mac_addend_vld  out  1  1-cycle addend strobe.
- mac_addend_din  out  32  accumulator value.
- mac_multiplicand_vld  out  1  1-cycle multiplicand strobe.
- mac_multiplicand_din  out  N  x operand.
- mac_multiplier_din  out  N  w operand, held stable from MUL until WAIT exits.
- mac_dout  in  32  MAC result.
- mac_dout_vld  in  1  MAC result strobe.

Behaviour:
- Reset:
  - All outputs are 0 and state goes to IDLE.
  - acc, idx and timer are cleared.
  - The top level drives the MAC rst_n = ~rst so the MAC resets in the same cycle.
  - Reset mid-operation aborts with no done pulse.
- All outputs are registered.
- States: IDLE, FETCH, ADD, MUL, WAIT, FIN, ERR.
- IDLE:
  - On start: latch len; acc<=bias; idx<=0; err<=0.
  - Go to FIN if len==0, else to FETCH.
  - Without start: no change.
- FETCH: x_rd_en = w_rd_en = 1, addr = idx; next state ADD.
- ADD:
  - Capture x_rd_data into mcand_reg and w_rd_data into mult_reg.
  - Drive mac_addend_vld=1 with mac_addend_din=acc; next state MUL.
- MUL:
  - Drive mac_multiplicand_vld=1 with mac_multiplicand_din=mcand_reg.
  - mac_multiplier_din=mult_reg, held through WAIT.
  - timer<=0; next state WAIT.
- WAIT:
  - Each cycle timer++.
  - On mac_dout_vld: acc<=mac_dout.
    - If idx==len-1, go to FIN.
    - Else idx<=idx+1 and go to FETCH.
  - Else if timer==TIMEOUT-1: go to ERR.
  - mac_dout_vld and timeout in the same cycle: mac_dout_vld wins.
- FIN: result<=acc; done=1 for this one cycle; next state IDLE.
- ERR: err<=1; result<=acc (partial sum); done=1 for one cycle; next state IDLE.
- start while busy is ignored (no queueing).
- mac_dout_vld outside WAIT is ignored and does not modify acc.
- Strobes (rd_en, addend_vld, multiplicand_vld) are exactly one cycle per term and 0 in all other states.
- Arithmetic is done entirely in the MAC; the sequencer only stores the 32-bit mac_dout. No saturation; wrap is inherited from the MAC.
- Timing:
  - Per term: 3 + L cycles, where L = cycles from the MUL cycle to the WAIT cycle sampling mac_dout_vld (L>=1).
  - Total from start sample to done: 1 + len*(3+L) + 1 cycles.
  - len==0: done is 2 cycles after start.
- len==2^AW: idx runs 0..2^AW-1; no address wrap before FIN.

Test Plan:
- Behavioural MAC model (dout = multiplicand*multiplier + addend, latency L=4) and RAM models are used throughout.
- Zero length: len=0, bias=5 -> done 2 cycles after start, result=5, no rd_en or MAC strobes, busy high for 2 cycles.
- Basic dot product: len=3, x={1,2,3}, w={4,5,6}, bias=10 -> result=42, done single pulse after 1+3*7+1 cycles, addresses 0,1,2 in order.
- Protocol check: every term has addend_vld exactly one cycle before multiplicand_vld, and mac_multiplier_din stable from MUL until mac_dout_vld. Stray mac_dout_vld=1 injected in IDLE and in ADD -> acc unchanged, result still 42.
- Timeout: MAC model never asserts vld, len=2, bias=7 -> ERR after TIMEOUT cycles in WAIT, done pulse, err=1, result=7. Next start clears err.
- Boundary and collision:
  - mac_dout_vld on the exact timeout cycle -> normal completion, err=0.
  - start pulsed while busy -> ignored, result unaffected.
- Reset mid-operation: rst in WAIT of term 1 -> busy=0, done never pulses, all outputs 0. A following start with len=1, x=3, w=3, bias=0 -> result=9.
